// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: tracks the destination registers of instructions that
// have already left ID. For each source operand of the ID instruction it
// chooses a forwarding stage, and it stalls ID when the value that operand
// needs is a load result that cannot be forwarded yet.
module forward_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  localparam int SELW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [NSRC*REG_AW-1:0] id_src,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   flush,
  output logic                   stall,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  output logic                   ex_valid,
  output logic [31:0]            stall_cnt
);

  // Tracker entry j describes the instruction in stage j (1 = EX).
  logic [DEPTH:1]    trk_valid;
  logic [DEPTH:1]    trk_regwrite;
  logic [DEPTH:1]    trk_memread;
  logic [REG_AW-1:0] trk_rd [1:DEPTH];

  logic [NSRC-1:0]      match_hit;
  logic [NSRC-1:0]      match_rdy;
  logic [NSRC*SELW-1:0] fwd_next;
  logic                 advance;

  // For each operand, find the youngest producer and decide whether it can
  // forward. Stage DEPTH is excluded: the register file covers it through
  // write-before-read.
  always_comb begin
    match_hit = '0;
    match_rdy = '0;
    fwd_next  = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int j = 1; j < DEPTH; j++) begin
        if (!match_hit[i] && id_src_used[i] && trk_valid[j] && trk_regwrite[j] &&
            (trk_rd[j] == id_src[i*REG_AW +: REG_AW]) && (trk_rd[j] != '0)) begin
          match_hit[i] = 1'b1;
          match_rdy[i] = !trk_memread[j] || (j >= 1 + LOAD_LAT);
          // Next cycle the producer has moved one stage further down.
          if (match_rdy[i]) begin
            fwd_next[i*SELW +: SELW] = SELW'(j + 1);
          end
        end
      end
    end
  end

  // A hazard counts only for a real instruction that is not being killed.
  always_comb begin
    stall   = id_valid && !flush && |(match_hit & ~match_rdy);
    advance = id_valid && !stall && !flush;
  end

  // Valid bits: shift every cycle. A flush kills the EX instruction as it
  // moves into MEM. A stalled or flushed ID leaves a bubble in EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_valid <= '0;
    end else begin
      for (int j = DEPTH; j >= 2; j--) begin
        trk_valid[j] <= trk_valid[j-1];
      end
      if (flush) begin
        trk_valid[2] <= 1'b0;
      end
      trk_valid[1] <= advance;
    end
  end

  // Payload fields follow the valid bits; they are ignored while valid is 0,
  // so they need no reset.
  always_ff @(posedge clk) begin
    for (int j = DEPTH; j >= 2; j--) begin
      trk_regwrite[j] <= trk_regwrite[j-1];
      trk_memread[j]  <= trk_memread[j-1];
      trk_rd[j]       <= trk_rd[j-1];
    end
    trk_regwrite[1] <= id_regwrite;
    trk_memread[1]  <= id_memread;
    trk_rd[1]       <= id_rd;
  end

  // Registered EX-side controls: the operand source select and the valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_sel  <= '0;
      ex_valid <= 1'b0;
    end else begin
      ex_valid <= advance;
      if (stall || flush) begin
        fwd_sel <= '0;
      end else begin
        fwd_sel <= fwd_next;
      end
    end
  end

  // Stall-cycle counter that saturates at its maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
